network_sequencer: RTL and testbench

Synthesizable controller that sequences the per-layer resets and start strobes of the neural-network datapath from the single system clock/reset pair. After reset it holds every layer in reset, releases layers one by one, then runs inference layer-by-layer on request. It monitors each layer for completion, and on a timeout forces a full re-reset of all layers. It sits between the top-level clock/reset source and the layer instances.

---
 rtl/network_sequencer_if.sv | 22 ++
 rtl/network_sequencer.sv | 115 +++++++++++
 tb/tb_network_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/network_sequencer_if.sv
// network_sequencer_if: control bundle between the sequencer and the layer instances
interface network_sequencer_if #(
  parameter int NUM_LAYERS = 3
);
  localparam int CLW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  logic                  run;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_reset;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [CLW-1:0]        current_layer;
  logic                  busy;
  logic                  done;
  logic                  error;
  modport master (
    input  run, layer_done,
    output layer_reset, layer_start, current_layer, busy, done, error
  );
  modport slave (
    output run, layer_done,
    input  layer_reset, layer_start, current_layer, busy, done, error
  );
endinterface

// File: rtl/network_sequencer.sv
// network_sequencer: staggered layer reset release, layer-by-layer inference strobes, timeout re-reset
module network_sequencer #(
  parameter int NUM_LAYERS        = 3,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int STAGGER_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input logic                  clock,
  input logic                  reset,
  network_sequencer_if.master  sq
);
  localparam int CLW  = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
  localparam int MAXA = RESET_HOLD_CYCLES > STAGGER_CYCLES ? RESET_HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAXC = MAXA > TIMEOUT_CYCLES ? MAXA : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int RW   = $clog2(NUM_LAYERS + 1);
  localparam logic [NUM_LAYERS-1:0] ONE = NUM_LAYERS'(1);
  typedef enum logic [2:0] {HOLD, RELEASE, IDLE, START, WAIT, FINISH} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         rel_q, rel_d;
  logic [NUM_LAYERS-1:0] layer_reset_q, layer_reset_d;
  logic [CLW-1:0]        cur_q, cur_d;
  logic                  error_q, error_d;
  logic                  hit;
  // only the active layer's done bit can advance the sequence
  assign hit              = |(sq.layer_done & (ONE << cur_q));
  assign sq.layer_reset   = layer_reset_q;
  assign sq.layer_start   = (state_q == START) ? (ONE << cur_q) : '0;
  assign sq.current_layer = cur_q;
  assign sq.busy          = state_q != IDLE;
  assign sq.done          = state_q == FINISH;
  assign sq.error         = error_q;
  // state, shared hold/stagger/timeout counter and release index
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      rel_q         <= '0;
      layer_reset_q <= '1;
      cur_q         <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rel_q         <= rel_d;
      layer_reset_q <= layer_reset_d;
      cur_q         <= cur_d;
      error_q       <= error_d;
    end
  end
  // next-state: hold, staggered release, then start/wait per layer until the last completes
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rel_d         = rel_q;
    layer_reset_d = layer_reset_q;
    cur_d         = cur_q;
    error_d       = error_q;
    case (state_q)
      HOLD: begin
        layer_reset_d = '1;
        if (cnt_q == CW'(RESET_HOLD_CYCLES - 1)) begin
          state_d       = RELEASE;
          cnt_d         = '0;
          rel_d         = RW'(1);
          layer_reset_d = ~ONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (rel_q == RW'(NUM_LAYERS)) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
          layer_reset_d = layer_reset_q & ~(ONE << rel_q);
          rel_d         = rel_q + 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (sq.run) begin
          state_d = START;
          cur_d   = '0;
          error_d = 1'b0;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (hit) begin
          state_d = (cur_q == CLW'(NUM_LAYERS - 1)) ? FINISH : START;
          cur_d   = (cur_q == CLW'(NUM_LAYERS - 1)) ? cur_q : cur_q + 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = HOLD;
          error_d       = 1'b1;
          cnt_d         = '0;
          cur_d         = '0;
          layer_reset_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        cur_d   = '0;
        state_d = IDLE;
      end
      default: state_d = HOLD;
    endcase
  end
endmodule

// File: tb/tb_network_sequencer.sv
// tb_network_sequencer: directed checks of release timing, inference pass, done filtering, timeout and reset
module tb_network_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  network_sequencer_if #(.NUM_LAYERS(3)) sq ();
  network_sequencer #(
    .NUM_LAYERS(3),
    .RESET_HOLD_CYCLES(4),
    .STAGGER_CYCLES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sq(sq.master)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic release_seq(input logic exp_err);
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("rel_lr_e%0d", e), 32'(sq.layer_reset), e < 4 ? 7 : e < 6 ? 6 : e < 8 ? 4 : 0);
      chk($sformatf("rel_busy_e%0d", e), 32'(sq.busy), e < 9 ? 1 : 0);
      chk($sformatf("rel_start_e%0d", e), 32'(sq.layer_start), 0);
      chk($sformatf("rel_err_e%0d", e), 32'(sq.error), 32'(exp_err));
      if (e == 4) sq.run = 1'b1;
      if (e == 7) sq.run = 1'b0;
    end
  endtask
  task automatic answer(input int i);
    repeat (5) begin
      tick();
      chk($sformatf("ans%0d_quiet", i), 32'(sq.layer_start), 0);
    end
    sq.layer_done = 3'(1 << i);
    tick();
    sq.layer_done = 3'b000;
    if (i < 2) begin
      chk($sformatf("ans%0d_next_strobe", i), 32'(sq.layer_start), 32'(1 << (i + 1)));
      chk($sformatf("ans%0d_next_layer", i), 32'(sq.current_layer), 32'(i + 1));
    end else begin
      chk("finish_done", 32'(sq.done), 1);
      chk("finish_start", 32'(sq.layer_start), 0);
    end
  endtask
  initial begin
    sq.run = 1'b0;
    sq.layer_done = 3'b000;
    repeat (3) tick();
    chk("rst_lr", 32'(sq.layer_reset), 7);
    chk("rst_start", 32'(sq.layer_start), 0);
    chk("rst_cl", 32'(sq.current_layer), 0);
    chk("rst_busy", 32'(sq.busy), 1);
    chk("rst_done", 32'(sq.done), 0);
    chk("rst_err", 32'(sq.error), 0);
    reset = 1'b0;
    release_seq(1'b0);
    repeat (2) begin
      tick();
      chk("idle_no_queued_start", 32'(sq.layer_start), 0);
      chk("idle_busy", 32'(sq.busy), 0);
    end
    sq.run = 1'b1;
    tick();
    sq.run = 1'b0;
    chk("pass_strobe0", 32'(sq.layer_start), 1);
    chk("pass_busy", 32'(sq.busy), 1);
    answer(0);
    answer(1);
    answer(2);
    tick();
    chk("pass_done_clear", 32'(sq.done), 0);
    chk("pass_cl_zero", 32'(sq.current_layer), 0);
    chk("pass_err", 32'(sq.error), 0);
    chk("pass_idle", 32'(sq.busy), 0);
    sq.run = 1'b1;
    tick();
    sq.run = 1'b0;
    chk("filt_strobe0", 32'(sq.layer_start), 1);
    sq.layer_done = 3'b101;
    tick();
    sq.layer_done = 3'b100;
    chk("filt_same_cycle_ignored", 32'(sq.layer_start), 0);
    chk("filt_cl0_a", 32'(sq.current_layer), 0);
    repeat (3) begin
      tick();
      chk("filt_other_ignored", 32'(sq.layer_start), 0);
      chk("filt_cl0_b", 32'(sq.current_layer), 0);
    end
    sq.layer_done = 3'b001;
    tick();
    sq.layer_done = 3'b000;
    chk("filt_strobe1", 32'(sq.layer_start), 2);
    chk("filt_cl1", 32'(sq.current_layer), 1);
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk("wait_no_strobe", 32'(sq.layer_start), 0);
      chk("wait_no_err", 32'(sq.error), 0);
      if (t == 3) sq.run = 1'b1;
      if (t == 6) sq.run = 1'b0;
    end
    tick();
    chk("limit_still_wait", 32'(sq.error), 0);
    sq.layer_done = 3'b010;
    tick();
    sq.layer_done = 3'b000;
    chk("limit_done_wins_err", 32'(sq.error), 0);
    chk("limit_done_wins_strobe", 32'(sq.layer_start), 4);
    chk("limit_cl2", 32'(sq.current_layer), 2);
    answer(2);
    tick();
    chk("filt_idle", 32'(sq.busy), 0);
    repeat (2) begin
      tick();
      chk("no_queued_pass", 32'(sq.layer_start), 0);
      chk("no_queued_busy", 32'(sq.busy), 0);
    end
    sq.run = 1'b1;
    tick();
    sq.run = 1'b0;
    chk("to_strobe0", 32'(sq.layer_start), 1);
    answer(0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("to_wait_err", 32'(sq.error), 0);
      chk("to_wait_lr", 32'(sq.layer_reset), 0);
    end
    tick();
    chk("to_err_set", 32'(sq.error), 1);
    chk("to_lr_all", 32'(sq.layer_reset), 7);
    chk("to_busy", 32'(sq.busy), 1);
    chk("to_cl", 32'(sq.current_layer), 0);
    release_seq(1'b1);
    tick();
    chk("to_idle_err_sticky", 32'(sq.error), 1);
    sq.run = 1'b1;
    tick();
    sq.run = 1'b0;
    chk("run_clears_err", 32'(sq.error), 0);
    chk("run_strobe0", 32'(sq.layer_start), 1);
    answer(0);
    repeat (2) tick();
    chk("mid_wait_cl1", 32'(sq.current_layer), 1);
    reset = 1'b1;
    tick();
    chk("midrst_lr", 32'(sq.layer_reset), 7);
    chk("midrst_start", 32'(sq.layer_start), 0);
    chk("midrst_busy", 32'(sq.busy), 1);
    chk("midrst_done", 32'(sq.done), 0);
    chk("midrst_err", 32'(sq.error), 0);
    chk("midrst_cl", 32'(sq.current_layer), 0);
    reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
